// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC definitions: link speed encoding, link speed monitor
// FSM states, default monitor thresholds and the period classifier.
package eth_mac_pkg;

   typedef enum logic [1:0] {
      SPEED_10M  = 2'b00,
      SPEED_100M = 2'b01,
      SPEED_1G   = 2'b10
   } link_speed_t;

   typedef enum logic {
      LSM_ACQUIRE = 1'b0,
      LSM_MEASURE = 1'b1
   } lsm_state_t;

   localparam int unsigned LSM_REF_CNT_WIDTH_DEF = 10;
   localparam int unsigned LSM_SYNC_STAGES_DEF   = 2;
   localparam int unsigned LSM_TH_1G_DEF         = 16;
   localparam int unsigned LSM_TH_100M_DEF       = 128;
   localparam int unsigned LSM_STABLE_COUNT_DEF  = 3;

   // Map a measured period (clk_125 cycles per divided rxc cycle) to a speed.
   function automatic link_speed_t lsm_classify(input int unsigned period,
                                                input int unsigned th_1g,
                                                input int unsigned th_100m);
      link_speed_t cls;
      if (period < th_1g) begin
         cls = SPEED_1G;
      end else if (period < th_100m) begin
         cls = SPEED_100M;
      end else begin
         cls = SPEED_10M;
      end
      return cls;
   endfunction

endpackage

// File: rtl/toggle_edge_sync.sv
// Synchronizes an asynchronous toggle into the local clock domain and emits a
// registered one-cycle pulse on each rising edge (latency SYNC_STAGES+1).
module toggle_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic toggle_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise_q;

   // Synchronizer chain, history flop and registered rising-edge detect.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
         hist_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/link_speed_monitor.sv
// Measures the period of the divided receive clock against clk_125, classifies
// it as 1G/100M/10M and updates link_speed once STABLE_COUNT consecutive
// measurements agree. Loss of the receive clock is flagged by a counter timeout.
module link_speed_monitor
   import eth_mac_pkg::*;
#(
   parameter int unsigned REF_CNT_WIDTH = LSM_REF_CNT_WIDTH_DEF,
   parameter int unsigned SYNC_STAGES   = LSM_SYNC_STAGES_DEF,
   parameter int unsigned TH_1G         = LSM_TH_1G_DEF,
   parameter int unsigned TH_100M       = LSM_TH_100M_DEF,
   parameter int unsigned STABLE_COUNT  = LSM_STABLE_COUNT_DEF
) (
   input  logic                     clk_125,
   input  logic                     reset_n,
   input  logic                     rxc_div_toggle,
   output logic [1:0]               link_speed,
   output logic                     mii_mode,
   output logic                     rxc_present,
   output logic                     speed_change,
   output logic [REF_CNT_WIDTH-1:0] period_o,
   output logic                     period_valid
);

   localparam logic [REF_CNT_WIDTH-1:0] CNT_ONE  = REF_CNT_WIDTH'(1);
   localparam logic [REF_CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [REF_CNT_WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;
   localparam int unsigned              AGREE_W  = $clog2(STABLE_COUNT + 1);
   localparam logic [AGREE_W-1:0]       AGREE_ONE = AGREE_W'(1);
   localparam logic [AGREE_W-1:0]       AGREE_MAX = AGREE_W'(STABLE_COUNT);

   logic                     rise;
   lsm_state_t               state_q, state_d;
   logic [REF_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     meas_valid;
   logic                     timeout;
   logic [REF_CNT_WIDTH-1:0] meas_p;
   link_speed_t              meas_class;
   logic [REF_CNT_WIDTH-1:0] period_q;
   logic                     period_valid_q;
   logic                     present_q;
   link_speed_t              cand_q;
   logic [AGREE_W-1:0]       agree_q;
   link_speed_t              speed_q;
   logic                     speed_change_q;

   toggle_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk_125),
      .rst_ni  (reset_n),
      .toggle_i(rxc_div_toggle),
      .rise_o  (rise)
   );

   // FSM state register.
   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LSM_ACQUIRE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arm on the first edge, fall back to ACQUIRE on timeout.
   // The counter would reach saturation on the cycle it leaves CNT_LAST, so
   // that cycle is the timeout unless an edge arrives in it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSM_ACQUIRE: if (rise) state_d = LSM_MEASURE;
         LSM_MEASURE: if (!rise && (cnt_q == CNT_LAST)) state_d = LSM_ACQUIRE;
         default:     state_d = LSM_ACQUIRE;
      endcase
   end

   // FSM outputs: measurement/timeout strobes and next counter value.
   always_comb begin
      meas_valid = 1'b0;
      timeout    = 1'b0;
      cnt_d      = '0;
      case (state_q)
         LSM_ACQUIRE: cnt_d = '0;
         LSM_MEASURE: begin
            if (rise) begin
               meas_valid = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Period counter.
   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q never exceeds CNT_LAST in MEASURE, so the increment cannot wrap.
   assign meas_p     = cnt_q + CNT_ONE;
   assign meas_class = lsm_classify(32'(meas_p), TH_1G, TH_100M);

   // Measurement result registers and receive-clock presence flag.
   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         period_q       <= '0;
         period_valid_q <= 1'b0;
         present_q      <= 1'b0;
      end else begin
         period_valid_q <= meas_valid;
         if (meas_valid) begin
            period_q  <= meas_p;
            present_q <= 1'b1;
         end else if (timeout) begin
            present_q <= 1'b0;
         end
      end
   end

   // Candidate class and saturating agreement count.
   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         cand_q  <= SPEED_1G;
         agree_q <= '0;
      end else if (timeout) begin
         agree_q <= '0;
      end else if (meas_valid) begin
         if (meas_class == cand_q) begin
            if (agree_q != AGREE_MAX) agree_q <= agree_q + AGREE_ONE;
         end else begin
            cand_q  <= meas_class;
            agree_q <= AGREE_ONE;
         end
      end
   end

   // Commit a stable candidate that differs from the current link speed.
   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         speed_q        <= SPEED_1G;
         speed_change_q <= 1'b0;
      end else begin
         speed_change_q <= 1'b0;
         if ((agree_q == AGREE_MAX) && (cand_q != speed_q)) begin
            speed_q        <= cand_q;
            speed_change_q <= 1'b1;
         end
      end
   end

   assign link_speed   = speed_q;
   assign mii_mode     = (speed_q != SPEED_1G);
   assign rxc_present  = present_q;
   assign speed_change = speed_change_q;
   assign period_o     = period_q;
   assign period_valid = period_valid_q;

endmodule
